dds_tuning_writer: RTL and testbench

//  Host-side driver for the DDS voice bank's shared tuning bus. Accepts voice commands
//  (voice index, waveform select, 16-bit tuning word) over valid/ready, buffers them in a

---
 rtl/dds_tuning_writer.sv | 167 ++++++++++++++++
 tb/tb_dds_tuning_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_tuning_writer.sv
// DDS voice-bank tuning bus writer: buffers voice commands in a small FIFO and replays
// each as a SETUP/HOLD strobed write. Define DDS_WRITER_GLIDE_EN to ramp tuning in steps.
module dds_tuning_writer #(
  parameter int TUNE_W     = 16,
  parameter int WAVE_W     = 3,
  parameter int NVOICE     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYC   = 2,
  parameter int GLIDE_STEP = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_voice,
  input  logic [WAVE_W-1:0] cmd_wave,
  input  logic [TUNE_W-1:0] cmd_tune,
  output logic [TUNE_W-1:0] tune_out,
  output logic [1:0]        voice_sel,
  output logic [WAVE_W-1:0] wave_sel,
  output logic              load_strb,
  output logic              busy,
  output logic              cmd_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a command transfers on any clk edge where cmd_valid and cmd_ready are both
  // high; cmd_ready depends only on FIFO occupancy, never on cmd_valid.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 2 + WAVE_W + TUNE_W;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              ready_en;
  logic [1:0]        state;
  logic [HW-1:0]     hold_cnt;

  logic              empty, full, accept, voice_ok, push, pop, start;
  logic [1:0]        head_voice, nxt_voice;
  logic [WAVE_W-1:0] head_wave, nxt_wave;
  logic [TUNE_W-1:0] head_tune, nxt_tune;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign cmd_ready = ready_en & ~full;
  assign accept    = cmd_valid & cmd_ready;
  assign voice_ok  = (int'(cmd_voice) < NVOICE);
  assign push      = accept & voice_ok;
  assign {head_voice, head_wave, head_tune} = fifo_mem[rd_ptr];
  assign dbg_state = state;

`ifdef DDS_WRITER_GLIDE_EN
  logic [TUNE_W-1:0] cur_tune [4];
  logic [1:0]        tgt_voice;
  logic [WAVE_W-1:0] tgt_wave;
  logic [TUNE_W-1:0] tgt_tune;
  logic              ramp_pending;
  logic [TUNE_W-1:0] src_tune, cur, step;

  // An unfinished ramp takes priority over the FIFO head.
  always_comb begin
    step      = TUNE_W'(GLIDE_STEP);
    nxt_voice = ramp_pending ? tgt_voice : head_voice;
    nxt_wave  = ramp_pending ? tgt_wave  : head_wave;
    src_tune  = ramp_pending ? tgt_tune  : head_tune;
    cur       = cur_tune[nxt_voice];
    nxt_tune  = src_tune;
    if (src_tune > cur) begin
      if (src_tune - cur > step) nxt_tune = cur + step;
    end else if (src_tune < cur) begin
      if (cur - src_tune > step) nxt_tune = cur - step;
    end
    start = (state == S_IDLE) & (ramp_pending | ~empty);
    pop   = (state == S_IDLE) & ~ramp_pending & ~empty;
  end

  assign busy = (state != S_IDLE) | ~empty | ramp_pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cur_tune[i] <= '0;
      tgt_voice    <= '0;
      tgt_wave     <= '0;
      tgt_tune     <= '0;
      ramp_pending <= 1'b0;
    end else begin
      if (pop) {tgt_voice, tgt_wave, tgt_tune} <= fifo_mem[rd_ptr];
      if (state == S_SETUP) begin
        cur_tune[voice_sel] <= tune_out;
        ramp_pending        <= (tune_out != tgt_tune);
      end
    end
  end
`else
  always_comb begin
    nxt_voice = head_voice;
    nxt_wave  = head_wave;
    nxt_tune  = head_tune;
    start     = (state == S_IDLE) & ~empty;
    pop       = start;
  end

  assign busy = (state != S_IDLE) | ~empty;
`endif

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_voice, cmd_wave, cmd_tune};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_en  <= 1'b0;
      cmd_err   <= 1'b0;
      state     <= S_IDLE;
      hold_cnt  <= '0;
      tune_out  <= '0;
      voice_sel <= '0;
      wave_sel  <= '0;
      load_strb <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      cmd_err  <= accept & ~voice_ok;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        S_IDLE: begin
          if (start) begin
            tune_out  <= nxt_tune;
            voice_sel <= nxt_voice;
            wave_sel  <= nxt_wave;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          load_strb <= 1'b1;
          hold_cnt  <= HW'(HOLD_CYC - 1);
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            load_strb <= 1'b0;
            state     <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_tuning_writer.sv
// Self-checking bench for dds_tuning_writer: directed scenarios followed by random commands
// checked against a per-command write-list model; glide scenario when DDS_WRITER_GLIDE_EN is set.
module tb_dds_tuning_writer;
  localparam int TUNE_W     = 16;
  localparam int WAVE_W     = 3;
  localparam int NVOICE     = 3;
  localparam int HOLD_CYC   = 2;
  localparam int GLIDE_STEP = 64;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_voice;
  logic [WAVE_W-1:0] cmd_wave;
  logic [TUNE_W-1:0] cmd_tune;
  logic [TUNE_W-1:0] tune_out;
  logic [1:0]        voice_sel;
  logic [WAVE_W-1:0] wave_sel;
  logic              load_strb;
  logic              busy;
  logic              cmd_err;
  logic [1:0]        dbg_state;

  dds_tuning_writer #(
    .TUNE_W(TUNE_W), .WAVE_W(WAVE_W), .NVOICE(NVOICE), .FIFO_DEPTH(4),
    .HOLD_CYC(HOLD_CYC), .GLIDE_STEP(GLIDE_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_voice(cmd_voice), .cmd_wave(cmd_wave), .cmd_tune(cmd_tune),
    .tune_out(tune_out), .voice_sel(voice_sel), .wave_sel(wave_sel),
    .load_strb(load_strb), .busy(busy), .cmd_err(cmd_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int tests  = 0;
  int failed = 0;
  int writes = 0;
  int run_len = 0;
  logic [20:0] exp_q[$];
  logic [15:0] obs_tunes[$];
  logic [20:0] cap_bus;
  int model_cur[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list of bus writes a command must produce, in order.
  task automatic model_cmd(input logic [1:0] v, input logic [2:0] w, input logic [15:0] t);
    if (int'(v) >= NVOICE) return;
`ifdef DDS_WRITER_GLIDE_EN
    begin
      int cur = model_cur[v];
      int tgt = int'(t);
      int nxt;
      do begin
        if (tgt > cur)      nxt = (tgt - cur > GLIDE_STEP) ? cur + GLIDE_STEP : tgt;
        else if (tgt < cur) nxt = (cur - tgt > GLIDE_STEP) ? cur - GLIDE_STEP : tgt;
        else                nxt = tgt;
        exp_q.push_back({v, w, 16'(nxt)});
        cur = nxt;
      end while (cur != tgt);
      model_cur[v] = tgt;
    end
`else
    exp_q.push_back({v, w, t});
`endif
  endtask

  // Driver: offer a command, waiting up to max_wait cycles for cmd_ready.
  task automatic send(input logic [1:0] v, input logic [2:0] w, input logic [15:0] t,
                      input int max_wait, output bit acc);
    int n = 0;
    cmd_voice = v; cmd_wave = w; cmd_tune = t; cmd_valid = 1'b1;
    while (!cmd_ready && n < max_wait) begin tick(); n++; end
    acc = cmd_ready;
    tick();
    cmd_valid = 1'b0;
    if (acc) model_cmd(v, w, t);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || load_strb) && n < bound) begin tick(); n++; end
    check("idle_timeout", {31'b0, busy | load_strb}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_cur[i] = 0;
    tick();
    check("rst_load_strb", {31'b0, load_strb}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_cmd_err",   {31'b0, cmd_err},   32'd0);
    check("rst_buses",     {11'b0, voice_sel, wave_sel, tune_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  // Scoreboard monitor: every strobe rising starts one write, compared to the model list.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (load_strb) begin
      if (run_len == 0) begin
        cap_bus = {voice_sel, wave_sel, tune_out};
        writes++;
        obs_tunes.push_back(tune_out);
        check("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("write_value", {11'b0, cap_bus}, {11'b0, exp_q.pop_front()});
      end else begin
        check("bus_hold", {11'b0, voice_sel, wave_sel, tune_out}, {11'b0, cap_bus});
      end
      run_len++;
    end else begin
      if (run_len != 0) check("strobe_len", run_len, HOLD_CYC);
      run_len = 0;
    end
  end

  localparam logic [15:0] T1 =
`ifdef DDS_WRITER_GLIDE_EN
    16'h0030;
`else
    16'h1234;
`endif

  initial begin
    bit acc;
    int w0;
    logic [1:0]  rv;
    logic [2:0]  rw;
    logic [15:0] rt;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_voice = '0; cmd_wave = '0; cmd_tune = '0;

    // Reset state
    do_reset();

    // Single command latency and strobe shape
    send(2'd1, 3'd2, T1, 0, acc);
    check("t1_accepted", {31'b0, acc}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_strb_c1", {31'b0, load_strb}, 32'd0);
    tick();
    check("t1_strb_c2", {31'b0, load_strb}, 32'd0);
    tick();
    check("t1_strb_c3", {31'b0, load_strb}, 32'd1);
    check("t1_voice", {30'b0, voice_sel}, 32'd1);
    check("t1_wave", {29'b0, wave_sel}, 32'd2);
    check("t1_tune", {16'b0, tune_out}, {16'b0, T1});
    tick();
    check("t1_strb_c4", {31'b0, load_strb}, 32'd1);
    tick();
    check("t1_strb_c5", {31'b0, load_strb}, 32'd0);
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_tune_kept", {16'b0, tune_out}, {16'b0, T1});

    // Back-to-back fill: FIFO reaches full while the writer is in HOLD
    w0 = writes;
    send(2'd0, 3'd1, 16'h0011, 0, acc); check("t2_acc1", {31'b0, acc}, 32'd1);
    send(2'd1, 3'd2, 16'h0022, 0, acc); check("t2_acc2", {31'b0, acc}, 32'd1);
    send(2'd2, 3'd3, 16'h0033, 0, acc); check("t2_acc3", {31'b0, acc}, 32'd1);
    send(2'd0, 3'd4, 16'h003c, 0, acc); check("t2_acc4", {31'b0, acc}, 32'd1);
    send(2'd1, 3'd5, 16'h0005, 0, acc); check("t2_acc5", {31'b0, acc}, 32'd1);
    check("t2_full_ready", {31'b0, cmd_ready}, 32'd0);
    send(2'd2, 3'd6, 16'h002a, 0, acc); check("t2_rejected", {31'b0, acc}, 32'd0);
    wait_idle(200);
    check("t2_writes", writes - w0, 32'd5);
    check("t2_drained", exp_q.size(), 32'd0);

    // Invalid voice is dropped with an error pulse
    w0 = writes;
    send(2'd3, 3'd1, 16'habcd, 0, acc);
    check("t3_accepted", {31'b0, acc}, 32'd1);
    check("t3_err_pulse", {31'b0, cmd_err}, 32'd1);
    check("t3_busy", {31'b0, busy}, 32'd0);
    tick();
    check("t3_err_drop", {31'b0, cmd_err}, 32'd0);
    repeat (6) tick();
    check("t3_no_write", writes - w0, 32'd0);

    // Reset while in HOLD with two commands queued
    send(2'd0, 3'd1, 16'h0001, 0, acc);
    send(2'd1, 3'd2, 16'h0002, 0, acc);
    send(2'd2, 3'd3, 16'h0003, 0, acc);
    check("t4_in_hold", {31'b0, load_strb}, 32'd1);
    w0 = writes;
    do_reset();
    repeat (12) tick();
    check("t4_no_replay", writes - w0, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd0);

    // Random commands with random gaps
    for (int i = 0; i < 30; i++) begin
      rv = 2'($urandom_range(0, 3));
      rw = 3'($urandom_range(0, 7));
`ifdef DDS_WRITER_GLIDE_EN
      rt = 16'($urandom_range(0, 700));
`else
      rt = 16'($urandom);
`endif
      send(rv, rw, rt, 2000, acc);
      check("rnd_accept", {31'b0, acc}, 32'd1);
      check("rnd_err", {31'b0, cmd_err}, {31'b0, int'(rv) >= NVOICE});
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle(5000);
    check("rnd_drained", exp_q.size(), 32'd0);

`ifdef DDS_WRITER_GLIDE_EN
    // Glide ramps from a known zero start
    begin
      logic [15:0] g_up[4];
      logic [15:0] g_dn[2];
      g_up = '{16'd64, 16'd128, 16'd192, 16'd200};
      g_dn = '{16'd136, 16'd100};
      do_reset();
      obs_tunes.delete();
      send(2'd0, 3'd0, 16'd200, 0, acc);
      wait_idle(500);
      check("g_up_count", obs_tunes.size(), 32'd4);
      for (int i = 0; i < 4; i++)
        if (i < obs_tunes.size()) check("g_up_step", {16'b0, obs_tunes[i]}, {16'b0, g_up[i]});
      obs_tunes.delete();
      send(2'd0, 3'd0, 16'd100, 0, acc);
      wait_idle(500);
      check("g_dn_count", obs_tunes.size(), 32'd2);
      for (int i = 0; i < 2; i++)
        if (i < obs_tunes.size()) check("g_dn_step", {16'b0, obs_tunes[i]}, {16'b0, g_dn[i]});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
